// File: rtl/cnn_layer_accel_awe_weight_sequencer.sv
// AWE weight sequencer: fills one private weight bank per read channel from a single
// write stream, then replays each bank independently in kernel-major or input-major order.
module cnn_layer_accel_awe_weight_sequencer #(
   parameter int C_WEIGHT_WIDTH    = 16,
   parameter int C_NUM_PORTS       = 2,
   parameter int C_BANK_DEPTH      = 512,
   parameter int C_BANK_ADDR_WIDTH = 9,
   parameter int C_PACKET_WIDTH    = 32
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     config_valid,
   input  logic [C_PACKET_WIDTH-1:0]                config_packet,
   output logic                                     config_ready,
   input  logic                                     wr_valid,
   output logic                                     wr_ready,
   input  logic [2*C_WEIGHT_WIDTH-1:0]              wr_data,
   input  logic [C_NUM_PORTS-1:0]                   rd_request,
   output logic [C_NUM_PORTS-1:0]                   rd_valid,
   output logic [C_NUM_PORTS*2*C_WEIGHT_WIDTH-1:0]  rd_data,
   output logic                                     busy,
   output logic                                     done,
   output logic                                     error
);

   // state | meaning
   // IDLE  | waiting for a config packet; config_ready high
   // LOAD  | filling banks 0..C_NUM_PORTS-1 from the write stream
   // READ  | per-channel replay until every channel has finished

   localparam int DW = 2*C_WEIGHT_WIDTH;
   localparam int AW = C_BANK_ADDR_WIDTH;
   localparam int BW = (C_NUM_PORTS > 1) ? $clog2(C_NUM_PORTS) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_READ} state_t;

   state_t          state_q, state_d;
   logic [7:0]      k_max_q, s_max_q, m_max_q;
   logic            order_q;
   logic [AW-1:0]   last_addr_q, s_len_q;
   logic [AW-1:0]   wr_addr_q;
   logic [BW-1:0]   bank_q;
   logic            done_q, error_q;

   logic [7:0]      cfg_k, cfg_s, cfg_m;
   logic [16:0]     cfg_n;
   logic            cfg_take, cfg_fits;
   logic            wr_fire, load_done, rd_finish;
   logic [C_NUM_PORTS-1:0] fin_vec, pend_vec;
   logic            unused_cfg_bits;

   assign cfg_k    = config_packet[7:0];
   assign cfg_s    = config_packet[15:8];
   assign cfg_m    = config_packet[23:16];
   assign cfg_n    = ({9'd0, cfg_k} + 17'd1) * ({9'd0, cfg_s} + 17'd1);
   assign cfg_fits = (cfg_n <= 17'(C_BANK_DEPTH));
   assign cfg_take = (state_q == ST_IDLE) && config_valid;
   assign unused_cfg_bits = ^config_packet[C_PACKET_WIDTH-1:25];

   assign wr_fire   = (state_q == ST_LOAD) && wr_valid;
   assign load_done = wr_fire && (wr_addr_q == last_addr_q) && (bank_q == BW'(C_NUM_PORTS-1));
   // Finish only once the last outstanding read has left the address stage.
   assign rd_finish = (state_q == ST_READ) && (&fin_vec) && (pend_vec == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      config_ready = 1'b0;
      wr_ready     = 1'b0;
      busy         = 1'b1;
      unique case (state_q)
         ST_IDLE: begin
            config_ready = 1'b1;
            busy         = 1'b0;
            if (cfg_take && cfg_fits) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            wr_ready = 1'b1;
            if (load_done) state_d = ST_READ;
         end
         ST_READ: begin
            if (rd_finish) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         k_max_q     <= '0;
         s_max_q     <= '0;
         m_max_q     <= '0;
         order_q     <= 1'b0;
         last_addr_q <= '0;
         s_len_q     <= '0;
         error_q     <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         error_q <= cfg_take && !cfg_fits;
         done_q  <= rd_finish;
         if (cfg_take && cfg_fits) begin
            k_max_q     <= cfg_k;
            s_max_q     <= cfg_s;
            m_max_q     <= cfg_m;
            order_q     <= config_packet[24];
            last_addr_q <= AW'(cfg_n - 17'd1);
            s_len_q     <= AW'({1'b0, cfg_s} + 9'd1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_addr_q <= '0;
         bank_q    <= '0;
      end else if (cfg_take) begin
         wr_addr_q <= '0;
         bank_q    <= '0;
      end else if (wr_fire) begin
         if (wr_addr_q == last_addr_q) begin
            wr_addr_q <= '0;
            bank_q    <= bank_q + BW'(1);
         end else begin
            wr_addr_q <= wr_addr_q + AW'(1);
         end
      end
   end

   assign done  = done_q;
   assign error = error_q;

   for (genvar p = 0; p < C_NUM_PORTS; p++) begin : g_ch
      logic [7:0]    w_q, k_q, m_q;
      logic [AW-1:0] base_q, raddr_q;
      logic          fin_q, pend_q, vld_q;
      logic [DW-1:0] dout_q;
      logic [DW-1:0] mem [C_BANK_DEPTH];
      logic          accept, w_last, k_last, m_last;

      assign accept = (state_q == ST_READ) && rd_request[p] && !fin_q;
      assign w_last = (w_q == s_max_q);
      assign k_last = (k_q == k_max_q);
      assign m_last = (m_q == m_max_q);

      // base_q tracks k*(S+1) incrementally so no multiplier sits in the read path.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            w_q     <= '0;
            k_q     <= '0;
            m_q     <= '0;
            base_q  <= '0;
            raddr_q <= '0;
            fin_q   <= 1'b0;
            pend_q  <= 1'b0;
         end else begin
            pend_q <= accept;
            if (accept) raddr_q <= base_q + AW'(w_q);
            if (state_q != ST_READ) begin
               w_q    <= '0;
               k_q    <= '0;
               m_q    <= '0;
               base_q <= '0;
               fin_q  <= 1'b0;
            end else if (accept) begin
               if (!w_last) begin
                  w_q <= w_q + 8'd1;
               end else begin
                  w_q <= '0;
                  if (order_q) begin
                     if (!k_last) begin
                        k_q    <= k_q + 8'd1;
                        base_q <= base_q + s_len_q;
                     end else begin
                        k_q    <= '0;
                        base_q <= '0;
                        if (m_last) fin_q <= 1'b1;
                        else        m_q   <= m_q + 8'd1;
                     end
                  end else begin
                     if (!m_last) begin
                        m_q <= m_q + 8'd1;
                     end else begin
                        m_q <= '0;
                        if (k_last) begin
                           fin_q <= 1'b1;
                        end else begin
                           k_q    <= k_q + 8'd1;
                           base_q <= base_q + s_len_q;
                        end
                     end
                  end
               end
            end
         end
      end

      always_ff @(posedge clk) begin
         if (wr_fire && (bank_q == BW'(p))) mem[wr_addr_q] <= wr_data;
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            vld_q  <= 1'b0;
            dout_q <= '0;
         end else begin
            vld_q <= pend_q;
            if (pend_q) dout_q <= mem[raddr_q];
         end
      end

      assign fin_vec[p]            = fin_q;
      assign pend_vec[p]           = pend_q;
      assign rd_valid[p]           = vld_q;
      assign rd_data[p*DW +: DW]   = dout_q;
   end

endmodule
